seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Time-multiplexed controller that shares one `seven_segment` hex decoder across the four digits of the board display. It drives a 16-bit value onto all four anodes in rotation, with a blanking gap between digits to suppress ghosting, plus per-digit enable and decimal-point control. It replaces the fixed single-anode drive in display top modules; counters and UART status sit upstream and write `data_in`.

## Interface
- `DRIVE_CYCLES`, default 100000: clock cycles a digit is lit per slot (1 ms at 100 MHz); must be ≥ 1.
- `BLANK_CYCLES`, default 1000: clock cycles all anodes are off before each digit; must be ≥ 1.
- `CLK`  in  1: system clock, rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `data_in`  in  16: four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `dp_in`  in  4: decimal point request per digit, active-high.
- `digit_en`  in  4: per-digit enable, active-high; a disabled digit stays dark for its whole slot.
- `blank_all`  in  1: forces the whole display dark.
- `segment`  out  7: cathodes, active-low, registered.
- `dp`  out  1: decimal point cathode, active-low, registered.
- `anode`  out  4: anodes, active-low, one-hot-low or all-high, registered.
- `digit_sel`  out  2: index of the current slot, registered.
- `frame_start`  out  1: one-cycle pulse on the first BLANK cycle of slot 0.

## Operation
- FSM states are BLANK and DRIVE. Reset enters BLANK with `digit_sel`=0 and the cycle counter at 0.
- BLANK: `anode`=4'b1111, `segment`=7'h7F, `dp`=1. After `BLANK_CYCLES` cycles the FSM goes to DRIVE, and the nibble `data_in[4*digit_sel +: 4]` and `dp_in[digit_sel]` are latched at that transition.
- DRIVE: the latched nibble goes to the decoder. The `anode` bit for `digit_sel` is 0 if `digit_en[digit_sel]`, otherwise all anodes stay 1. `dp` = ~latched dp. After `DRIVE_CYCLES` cycles the FSM goes to BLANK and `digit_sel` increments mod 4 (3 → 0).
- Disabled digits still consume a full slot, so brightness is independent of the enable pattern.
- `blank_all`=1 forces `anode`=4'b1111, `segment`=7'h7F and `dp`=1 on the next edge. The FSM, counter and `digit_sel` keep running, so the rotation phase is preserved.
- `data_in` changes during DRIVE take effect only at the next slot's latch. There is no tearing within a digit.
- Reset assertion mid-slot immediately (asynchronously) sets `anode`=4'b1111, `segment`=7'h7F, `dp`=1, `digit_sel`=0, `frame_start`=0 and state BLANK.

## Timing
- Slot length is B+D cycles, where B=`BLANK_CYCLES` and D=`DRIVE_CYCLES`. Frame length is 4(B+D). `frame_start` period equals the frame length.
- Output pins lag the internal state by exactly one cycle because all outputs are registered.
- After reset release, the first rising edge is cycle 0 of slot 0 BLANK and `frame_start`=1 on that cycle's output. Anode 0 first goes low at output cycle B.
- Between any two lit digits, `anode` is 4'b1111 for exactly B cycles. Two anode bits are never low at the same time.
- The counter width is `$clog2` of max(B, D) + 1. The counter resets to 0 on every state change and never wraps within a state.

## Structure
- Package `seg_scan_pkg` holds:
  - the state typedef `scan_state_t` {BLANK, DRIVE};
  - constants `SEG_OFF`=7'h7F and `ANODE_OFF`=4'hF.
- Sub-module: the existing `seven_segment` decoder, instantiated once on the latched nibble. Its output is registered in this block.
- Parameter legality is checked with elaboration-time assertions (B ≥ 1, D ≥ 1).

## Test plan
All scenarios use B=2 and D=5.
- Reset, then idle with `data_in`=16'h1234 and `digit_en`=4'hF:
  - `anode` sequence is 1111×2, 1110×5, 1111×2, 1101×5, 1111×2, 1011×5, 1111×2, 0111×5, repeating.
  - `segment` is the decode of 4, 3, 2, 1 during the respective DRIVE windows.
  - `frame_start` pulses every 28 cycles.
- `data_in` changed from 16'h00FF to 16'h0000 mid-DRIVE of digit 0 → digit 0 keeps showing F until the slot ends, and digit 1 shows 0.
- `digit_en`=4'b0101 → `anode` never shows 1101 or 0111. Slot timing is unchanged: `frame_start` is still every 28 cycles.
- `dp_in`=4'b0010 → `dp`=0 only during the digit 1 DRIVE window, and 1 everywhere else.
- `blank_all` pulsed for 10 cycles → `anode`=1111 and `segment`=7F from the next edge for 10 cycles. The rotation then resumes at the phase it would have had without the pulse.
- `RST_N` asserted during digit 2 DRIVE → outputs go dark with no clock edge. On release, `digit_sel`=0 and the scan restarts at slot 0 BLANK.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_segment
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_hex)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexes one hex decoder across four anodes, with an all-dark
// gap before every digit to suppress ghosting.
module seven_segment_scanner
    import seg_scan_pkg::*;
#(
    parameter int DRIVE_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        blank_all,
    output logic [6:0]  segment,
    output logic        dp,
    output logic [3:0]  anode,
    output logic [1:0]  digit_sel,
    output logic        frame_start
);

    localparam int MAX_C = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DRIVE_CYCLES - 1);

    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("BLANK_CYCLES must be >= 1");
    end
    if (DRIVE_CYCLES < 1) begin : g_bad_drive
        $error("DRIVE_CYCLES must be >= 1");
    end

    scan_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic          w_latch;
    logic [3:0]    r_nib;
    logic          r_dp_req;
    logic [6:0]    w_seg_dec;
    logic          w_dark;
    logic [3:0]    w_anode;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Counter restarts on every state change, so it never wraps inside a state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_sel_nxt   = r_sel;
        w_latch     = 1'b0;
        case (r_state)
            BLANK: if (r_cnt == B_LAST) begin
                w_state_nxt = DRIVE;
                w_cnt_nxt   = '0;
                w_latch     = 1'b1;
            end
            DRIVE: if (r_cnt == D_LAST) begin
                w_state_nxt = BLANK;
                w_cnt_nxt   = '0;
                w_sel_nxt   = r_sel + 2'd1;
            end
            default: begin
                w_state_nxt = BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Snapshot taken once per slot so upstream writes cannot tear a digit.
    always_ff @(posedge CLK) begin
        if (w_latch) begin
            r_nib    <= data_in[{r_sel, 2'b00} +: 4];
            r_dp_req <= dp_in[r_sel];
        end
    end

    seven_segment u_dec (
        .i_hex (r_nib),
        .o_seg (w_seg_dec)
    );

    assign w_dark = blank_all || (r_state == BLANK);

    always_comb begin
        w_anode = ANODE_OFF;
        if (!w_dark && digit_en[r_sel]) begin
            w_anode[r_sel] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            anode       <= ANODE_OFF;
            segment     <= SEG_OFF;
            dp          <= 1'b1;
            digit_sel   <= 2'd0;
            frame_start <= 1'b0;
        end else begin
            anode       <= w_anode;
            segment     <= w_dark ? SEG_OFF : w_seg_dec;
            dp          <= w_dark ? 1'b1 : ~r_dp_req;
            digit_sel   <= r_sel;
            frame_start <= (r_state == BLANK) && (r_cnt == '0) && (r_sel == 2'd0);
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with B=2, D=5 and a slot/frame arithmetic model.
module tb_seven_segment_scanner;

    localparam int B     = 2;
    localparam int D     = 5;
    localparam int SLOT  = B + D;
    localparam int FRAME = 4 * SLOT;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_all;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  anode;
    logic [1:0]  digit_sel;
    logic        frame_start;

    seven_segment_scanner #(
        .DRIVE_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .blank_all   (blank_all),
        .segment     (segment),
        .dp          (dp),
        .anode       (anode),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Model state: k counts output edges since reset release.
    int         k = 0;
    logic [3:0] lat_nib = 4'h0;
    logic       lat_dp  = 1'b0;
    logic [3:0] exp_anode = 4'hF;
    logic [6:0] exp_seg   = 7'h7F;
    logic       exp_dp    = 1'b1;
    logic [1:0] exp_sel   = 2'd0;
    logic       exp_fs    = 1'b0;

    function automatic logic [6:0] dec(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        int pos;
        int s;
        logic dark;
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                k         = 0;
                exp_anode = 4'hF;
                exp_seg   = 7'h7F;
                exp_dp    = 1'b1;
                exp_sel   = 2'd0;
                exp_fs    = 1'b0;
            end else begin
                pos       = k % SLOT;
                s         = (k / SLOT) % 4;
                dark      = blank_all || (pos < B);
                exp_anode = (dark || !digit_en[s]) ? 4'hF : ~(4'b0001 << s);
                exp_seg   = dark ? 7'h7F : dec(lat_nib);
                exp_dp    = dark ? 1'b1 : ~lat_dp;
                exp_sel   = s[1:0];
                exp_fs    = ((k % FRAME) == 0);
                if (pos == B - 1) begin
                    lat_nib = data_in[4*s +: 4];
                    lat_dp  = dp_in[s];
                end
                k++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("anode", 32'(anode), 32'(exp_anode));
                chk("segment", 32'(segment), 32'(exp_seg));
                chk("dp", 32'(dp), 32'(exp_dp));
                chk("digit_sel", 32'(digit_sel), 32'(exp_sel));
                chk("frame_start", 32'(frame_start), 32'(exp_fs));
            end
        end
    end

    task automatic goto(input int n);
        int guard = 0;
        while (k != n + 1 && guard < 2000) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        n_checks++;
        if (k != n + 1) begin
            n_fail++;
            $display("FAIL goto_edge_%0d: reached %0d expected %0d", n, k - 1, n);
        end
    endtask

    initial begin
        RST_N     = 1'b1;
        data_in   = 16'h1234;
        dp_in     = 4'h0;
        digit_en  = 4'hF;
        blank_all = 1'b0;
        #3 RST_N  = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_segment", 32'(segment), 32'h7F);
        chk("rst_fs", 32'(frame_start), 32'h0);
        RST_N = 1'b1;

        goto(0);   chk("e0_fs", 32'(frame_start), 32'h1); chk("e0_anode", 32'(anode), 32'hF);
        goto(2);   chk("e2_anode", 32'(anode), 32'hE);    chk("e2_seg", 32'(segment), 32'h19);
        goto(9);   chk("e9_anode", 32'(anode), 32'hD);    chk("e9_seg", 32'(segment), 32'h30);
        goto(28);  chk("e28_fs", 32'(frame_start), 32'h1);

        goto(56);  data_in = 16'h00FF;
        goto(59);  data_in = 16'h0000;
        goto(61);  chk("e61_seg_held_F", 32'(segment), 32'h0E); chk("e61_anode", 32'(anode), 32'hE);
        goto(65);  chk("e65_seg_0", 32'(segment), 32'h40);      chk("e65_anode", 32'(anode), 32'hD);

        goto(83);  data_in = 16'h1234; digit_en = 4'b0101;
        goto(86);  chk("e86_anode_en0", 32'(anode), 32'hE);
        goto(93);  chk("e93_anode_dis1", 32'(anode), 32'hF);
        goto(111); digit_en = 4'hF; dp_in = 4'b0010;
        goto(112); chk("e112_fs", 32'(frame_start), 32'h1);
        goto(114); chk("e114_dp", 32'(dp), 32'h1);
        goto(121); chk("e121_dp", 32'(dp), 32'h0);

        goto(140); dp_in = 4'h0;
        goto(142); blank_all = 1'b1;
        goto(150); chk("e150_anode_blank", 32'(anode), 32'hF); chk("e150_seg_blank", 32'(segment), 32'h7F);
                   chk("e150_sel", 32'(digit_sel), 32'h1);
        goto(152); blank_all = 1'b0;
        goto(153); chk("e153_anode_resume", 32'(anode), 32'hD);

        goto(184); chk("e184_anode_d2", 32'(anode), 32'hB);
        #1 RST_N = 1'b0;
        #2;
        chk("async_anode", 32'(anode), 32'hF);
        chk("async_seg", 32'(segment), 32'h7F);
        chk("async_dp", 32'(dp), 32'h1);
        chk("async_sel", 32'(digit_sel), 32'h0);
        chk("async_fs", 32'(frame_start), 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        goto(0);   chk("r0_fs", 32'(frame_start), 32'h1); chk("r0_sel", 32'(digit_sel), 32'h0);
        goto(2);   chk("r2_anode", 32'(anode), 32'hE);    chk("r2_seg", 32'(segment), 32'h19);
        goto(30);
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
